// File: rtl/paraserial_n.sv
`default_nettype none
// ============================================================================
//  Module   : paraserial_n
//  Purpose  : Parametrised parallel-to-serial converter. Words arrive through
//             a valid/ready handshake with a one-entry holding buffer and are
//             shifted out one bit per clk_8f cycle. After reset a programmable
//             number of idle words is sent for receiver alignment, and every
//             gap in the input stream is filled with whole idle words.
//  Revision : 1.0  initial release
// ============================================================================
module paraserial_n #(
  parameter int          WIDTH      = 8,
  parameter int unsigned IDLE       = 'hBC,
  parameter int          SYNC_WORDS = 4,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic             clk_8f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             data_out,
  output logic             frame_start,
  output logic             active_out
);

  localparam int                CNT_W     = $clog2(WIDTH);
  localparam int                SYNC_W    = $clog2(SYNC_WORDS + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_WORDS);
  localparam logic [WIDTH-1:0]  IDLE_WORD = WIDTH'(IDLE);

  typedef enum logic [0:0] {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [SYNC_W-1:0]   sync_cnt;
  logic [SYNC_W-1:0]   sync_cnt_next;
  logic [CNT_W-1:0]    bit_cnt;
  logic [WIDTH-1:0]    shift_reg;
  logic [WIDTH-1:0]    hold_data;
  logic                hold_full;

  logic                load;
  logic                sel_hold;
  logic                accept;
  logic [WIDTH-1:0]    word;
  logic                load_bit;
  logic [WIDTH-1:0]    load_rest;
  logic                shift_bit;
  logic [WIDTH-1:0]    shift_rest;

  // A load edge starts a new word; the held word wins only once aligned.
  assign load      = (bit_cnt == '0);
  assign sel_hold  = (state == ST_ACTIVE) && hold_full;
  assign word      = sel_hold ? hold_data : IDLE_WORD;
  assign ready_out = (state == ST_ACTIVE) && (!hold_full || load);
  assign accept    = valid_in && ready_out;

  // Transmit order: the shifter always presents the next bit at one end.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign load_bit   = word[WIDTH-1];
      assign load_rest  = {word[WIDTH-2:0], 1'b0};
      assign shift_bit  = shift_reg[WIDTH-1];
      assign shift_rest = {shift_reg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign load_bit   = word[0];
      assign load_rest  = {1'b0, word[WIDTH-1:1]};
      assign shift_bit  = shift_reg[0];
      assign shift_rest = {1'b0, shift_reg[WIDTH-1:1]};
    end
  endgenerate

  // State and alignment counter registers.
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state    <= ST_SYNC;
      sync_cnt <= '0;
    end else begin
      state    <= next_state;
      sync_cnt <= sync_cnt_next;
    end
  end

  // Count idle words sent in SYNC; go ACTIVE on the last one.
  always_comb begin
    next_state    = state;
    sync_cnt_next = sync_cnt;
    if ((state == ST_SYNC) && load) begin
      sync_cnt_next = sync_cnt + SYNC_W'(1);
      if (sync_cnt_next == SYNC_LAST) begin
        next_state = ST_ACTIVE;
      end
    end
  end

  // Bit counter, shifter and registered serial outputs.
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      bit_cnt     <= '0;
      shift_reg   <= '0;
      data_out    <= 1'b0;
      frame_start <= 1'b0;
      active_out  <= 1'b0;
    end else begin
      bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);
      if (load) begin
        data_out    <= load_bit;
        shift_reg   <= load_rest;
        frame_start <= 1'b1;
        active_out  <= sel_hold;
      end else begin
        data_out    <= shift_bit;
        shift_reg   <= shift_rest;
        frame_start <= 1'b0;
      end
    end
  end

  // Holding-buffer occupancy; a new accept on a load edge refills it at once.
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_full <= 1'b1;
    end else if (load && sel_hold) begin
      hold_full <= 1'b0;
    end
  end

  // Holding-buffer payload; only meaningful while hold_full is set.
  always_ff @(posedge clk_8f) begin
    if (accept) begin
      hold_data <= data_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_paraserial_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_paraserial_n
//  Purpose  : Directed self-checking bench for paraserial_n (MSB-first 8-bit
//             instance and an LSB-first 4-bit instance).
//  Revision : 1.0  initial release
// ============================================================================
module tb_paraserial_n;

  logic       clk_8f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       frame_start;
  logic       active_out;

  logic       rst4;
  logic [3:0] data4;
  logic       valid4;
  logic       ready4;
  logic       dout4;
  logic       fs4;
  logic       act4;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] q[$];
  int         sched_e[$];
  logic [7:0] sched_w[$];
  int         gap_lo;
  int         gap_hi;
  logic [7:0] slot_word [0:31];
  bit         slot_act  [0:31];
  bit         exp4_bit  [0:8];
  bit         exp4_act  [0:8];

  paraserial_n #(
    .WIDTH(8), .IDLE('hBC), .SYNC_WORDS(2), .MSB_FIRST(1'b1)
  ) dut (
    .clk_8f(clk_8f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .frame_start(frame_start),
    .active_out(active_out)
  );

  paraserial_n #(
    .WIDTH(4), .IDLE('hBC), .SYNC_WORDS(1), .MSB_FIRST(1'b0)
  ) dut4 (
    .clk_8f(clk_8f), .reset(rst4), .data_in(data4), .valid_in(valid4),
    .ready_out(ready4), .data_out(dout4), .frame_start(fs4),
    .active_out(act4)
  );

  always #5 clk_8f = ~clk_8f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_8f);
    #1;
  endtask

  task automatic clear_slots();
    for (int s = 0; s < 32; s++) begin
      slot_word[s] = 8'hBC;
      slot_act[s]  = 1'b0;
    end
  endtask

  task automatic set_slot(input int s, input logic [7:0] w);
    slot_word[s] = w;
    slot_act[s]  = 1'b1;
  endtask

  task automatic sched(input int e, input logic [7:0] w);
    sched_e.push_back(e);
    sched_w.push_back(w);
  endtask

  // Runs edges 0..last after reset release, driving the word queue through the
  // handshake and checking every serial output against the slot table.
  task automatic run_edges(input int last, input bit stream_chk);
    for (int e = 0; e <= last; e++) begin
      logic       acc;
      logic [7:0] w;
      int         s;
      int         b;
      valid_in = (q.size() > 0) && !(e >= gap_lo && e <= gap_hi);
      data_in  = valid_in ? q[0] : 8'h00;
      acc      = valid_in && ready_out;
      tick();
      if (acc) q.delete(0);
      s = e / 8;
      w = slot_word[s];
      b = 7 - (e % 8);
      check($sformatf("data_out@%0d", e), data_out, w[b]);
      check($sformatf("frame_start@%0d", e), frame_start, (e % 8) == 0);
      check($sformatf("active_out@%0d", e), active_out, slot_act[s]);
      if (e == 7 || e == 9) check($sformatf("ready_out@%0d", e), ready_out, 0);
      if (e == 8)           check($sformatf("ready_out@%0d", e), ready_out, 1);
      if (stream_chk && e >= 32 && e <= 95)
        check($sformatf("ready_stream@%0d", e), ready_out, (e % 8) == 7);
      while (sched_e.size() > 0 && sched_e[0] == e) begin
        q.push_back(sched_w[0]);
        sched_e.delete(0);
        sched_w.delete(0);
      end
    end
    valid_in = 1'b0;
    data_in  = 8'h00;
  endtask

  initial begin
    reset    = 1'b0;
    rst4     = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    valid4   = 1'b0;
    data4    = 4'h0;
    exp4_bit = '{0, 0, 1, 1, 1, 1, 0, 0, 0};
    exp4_act = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    tick();
    tick();
    check("rst_data_out", data_out, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_active_out", active_out, 0);
    check("rst_ready_out", ready_out, 0);

    // Sync, single word, back-to-back stream, gap, then two words for reset.
    clear_slots();
    set_slot(2, 8'hA5);
    for (int k = 1; k <= 10; k++) set_slot(k + 3, 8'(k));
    set_slot(15, 8'h11);
    set_slot(16, 8'h22);
    set_slot(18, 8'h33);
    set_slot(19, 8'h44);
    set_slot(22, 8'h5A);
    sched(8, 8'hA5);
    for (int k = 1; k <= 10; k++) sched(24, 8'(k));
    sched(112, 8'h11);
    sched(112, 8'h22);
    sched(112, 8'h33);
    sched(112, 8'h44);
    sched(167, 8'h5A);
    sched(167, 8'h77);
    gap_lo = 128;
    gap_hi = 139;
    reset  = 1'b1;
    run_edges(179, 1'b1);

    // Reset lands on bit 3 of 0x5A while 0x77 sits in the holding buffer.
    reset = 1'b0;
    #1;
    check("midrst_data_out", data_out, 0);
    check("midrst_frame_start", frame_start, 0);
    check("midrst_active_out", active_out, 0);
    check("midrst_ready_out", ready_out, 0);
    tick();
    check("midrst_hold_data_out", data_out, 0);

    // After release a full idle sequence precedes new data; 0x77 is gone.
    clear_slots();
    set_slot(2, 8'hC3);
    q.delete();
    q.push_back(8'hC3);
    gap_lo = -1;
    gap_hi = -1;
    reset  = 1'b1;
    run_edges(31, 1'b0);

    // LSB-first 4-bit instance: idle 4'hC then 4'b0011.
    check("w4_rst_data_out", dout4, 0);
    check("w4_rst_ready", ready4, 0);
    rst4 = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      tick();
      check($sformatf("w4_data_out@%0d", e), dout4, exp4_bit[e]);
      check($sformatf("w4_frame_start@%0d", e), fs4, (e % 4) == 0);
      check($sformatf("w4_active_out@%0d", e), act4, exp4_act[e]);
      if (e == 0) begin
        check("w4_ready@0", ready4, 1);
        valid4 = 1'b1;
        data4  = 4'b0011;
      end else begin
        valid4 = 1'b0;
        data4  = 4'h0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
